msi_irq_dispatch: RTL and testbench
===================================

// Module: msi_irq_dispatch
// PURPOSE
//  Collects interrupt requests from NUM_VEC user sources, keeps a per-vector pending bit,
//  selects vectors round-robin and hands one MSI (address + data) at a time to the
//  downstream MSI AXI write master via its start/addr/data inputs. Sits directly upstream
//  of that master and throttles on the master's state output so no request is lost.
// PARAMETERS
//  NUM_VEC   8     number of interrupt sources / vectors (2..32)
//  HOLDOFF   4     low cycles on msi_start after master returns to IDLE (min 3)
//  TIMEOUT   1024  cycles to wait in S_REQ for master to leave IDLE before abort
// PORTS
//  clk               in   1        clock
//  rst               in   1        synchronous reset, active-high
//  irq_in            in   NUM_VEC  source requests; rising edge raises pending
//  msi_enable        in   1        0 = hold issuing (pending still accumulates)
//  vec_mask          in   NUM_VEC  1 = vector masked (kept pending, not issued)
//  cfg_msi_addr      in   32       MSI target address
//  cfg_msi_data      in   16       MSI base data
//  cfg_mme           in   3        log2 of allocated vectors (0..5)
//  mst_state         in   8        write master state; 0 = IDLE
//  msi_start         out  1        start level to master
//  msi_addr          out  32       address to master
//  msi_data          out  16       data to master
//  pending           out  NUM_VEC  pending bits
//  busy              out  1        FSM not in S_IDLE
//  issue_count       out  16       MSIs handed off, wraps 0xFFFF->0
//  err_timeout       out  1        sticky: a request was aborted by TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0, pending 0, irq_in history 0, rr pointer 0, FSM S_IDLE.
//  Edge detect: irq_q <= irq_in; set_v = irq_in & ~irq_q. Level held high = one request.
//  pending_next = (pending & ~clr) | set; set wins over clear in same cycle.
//  Eligible = pending & ~vec_mask; selection only in S_IDLE with msi_enable=1.
//  Round-robin: search from rr_ptr upward, wrap at NUM_VEC; rr_ptr <= winner+1 (mod NUM_VEC).
//  Data: m = (1<<cfg_mme)-1; msi_data = (cfg_msi_data & ~m) | (vec & m) (vec zero-extended
//   to 16 b; vectors >= allocated alias by low bits). msi_addr = cfg_msi_addr.
//  FSM:
//   S_IDLE : eligible!=0 & msi_enable -> latch msi_addr/msi_data, clear winner pending,
//            msi_start<=1, go S_REQ (start visible 1 cycle after selection).
//   S_REQ  : mst_state!=0 -> msi_start<=0, S_WAIT, issue_count++.
//            timer==TIMEOUT-1 -> msi_start<=0, re-set winner pending, err_timeout<=1, S_GAP.
//   S_WAIT : mst_state==0 -> S_GAP.
//   S_GAP  : msi_start=0 for HOLDOFF cycles (counter), then S_IDLE.
//  msi_addr/msi_data stable from start rise until FSM leaves S_GAP (master re-reads data
//   for its second write). cfg_* changes mid-request do not affect the latched values.
//  msi_enable falling mid-request: in-flight request completes; no new selection.
//  vec_mask set on a latched vector: request still completes.
//  Only one request in flight; next start no earlier than HOLDOFF+1 cycles after mst_state=0.
//  rst mid-request: immediate S_IDLE, msi_start=0, pending cleared (request lost).
// TESTING
//  1 irq_in[3] 0->1, cfg_addr=0xFEE0_0000, data=0x4020, mme=3, master model -> one start,
//    addr 0xFEE0_0000, data 0x4023, issue_count=1, pending=0.
//  2 irq_in=0xFF same cycle, no mask -> 8 starts in order 0..7, each spaced >=HOLDOFF+1
//    cycles after mst_state=0; data low bits 0..7.
//  3 mme=1, irq_in[6] -> data low bit = 0 (0x4020); vector 5 -> 0x4021.
//  4 vec_mask=0x04, irq_in[2] rises -> pending=0x04, no start; unmask -> start issued.
//  5 mst_state held 0 -> start high TIMEOUT cycles, drops, err_timeout=1, pending bit reset.
//  6 irq_in[1] rises again while vector 1 in S_WAIT -> pending[1]=1, second MSI follows;
//    rst asserted in S_REQ -> start=0, pending=0 next cycle.

Source files
------------

// File: rtl/msi_irq_dispatch.sv
// msi_irq_dispatch: edge-detected interrupt sources with per-vector pending bits,
// round-robin selection and one-at-a-time MSI handoff to the downstream AXI write master.
module msi_irq_dispatch #(
    parameter int NUM_VEC = 8,
    parameter int HOLDOFF = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_VEC-1:0] irq_in,
    input  logic               msi_enable,
    input  logic [NUM_VEC-1:0] vec_mask,
    input  logic [31:0]        cfg_msi_addr,
    input  logic [15:0]        cfg_msi_data,
    input  logic [2:0]         cfg_mme,
    input  logic [7:0]         mst_state,
    output logic               msi_start,
    output logic [31:0]        msi_addr,
    output logic [15:0]        msi_data,
    output logic [NUM_VEC-1:0] pending,
    output logic               busy,
    output logic [15:0]        issue_count,
    output logic               err_timeout
);
    localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int CW = $clog2(TIMEOUT + HOLDOFF + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} state_t;
    state_t state, state_next;

    logic [NUM_VEC-1:0] irq_q, set_v, clr_v, rearm_v, eligible;
    logic [VW-1:0]      rr_ptr, sel_vec, cur_vec, cand;
    logic               sel_found, take, req_ack, req_abort, gap_done;
    logic [CW-1:0]      cnt;
    int                 sel_idx;

    // Vectors beyond the allocated count alias onto the low data bits.
    function automatic logic [15:0] msi_data_f(input logic [15:0] base, input logic [2:0] mme,
                                               input logic [VW-1:0] vec);
        logic [15:0] m;
        m = 16'((17'd1 << mme) - 17'd1);
        return (base & ~m) | (16'(vec) & m);
    endfunction

    function automatic logic [VW-1:0] vec_inc(input logic [VW-1:0] v);
        return (int'(v) == NUM_VEC - 1) ? '0 : v + 1'b1;
    endfunction

    assign set_v     = irq_in & ~irq_q;
    assign eligible  = pending & ~vec_mask;
    assign take      = (state == S_IDLE) && msi_enable && sel_found;
    assign req_ack   = (state == S_REQ) && (mst_state != 8'd0);
    assign req_abort = (state == S_REQ) && (mst_state == 8'd0) && (cnt == CW'(TIMEOUT - 1));
    assign gap_done  = (state == S_GAP) && (cnt == CW'(HOLDOFF - 1));
    assign clr_v     = take ? (NUM_VEC'(1) << sel_vec) : '0;
    assign rearm_v   = req_abort ? (NUM_VEC'(1) << cur_vec) : '0;

    // Round-robin search starting at rr_ptr, wrapping at NUM_VEC.
    always_comb begin
        sel_found = 1'b0;
        sel_vec   = '0;
        sel_idx   = 0;
        cand      = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            sel_idx = int'(rr_ptr) + i;
            if (sel_idx >= NUM_VEC) sel_idx = sel_idx - NUM_VEC;
            cand = VW'(sel_idx);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_vec   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (take) state_next = S_REQ;
            S_REQ: begin
                if (req_ack)        state_next = S_WAIT;
                else if (req_abort) state_next = S_GAP;
            end
            S_WAIT: if (mst_state == 8'd0) state_next = S_GAP;
            S_GAP:  if (gap_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        msi_start = (state == S_REQ);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q       <= '0;
            pending     <= '0;
            rr_ptr      <= '0;
            cur_vec     <= '0;
            cnt         <= '0;
            msi_addr    <= '0;
            msi_data    <= '0;
            issue_count <= '0;
            err_timeout <= 1'b0;
        end else begin
            irq_q   <= irq_in;
            pending <= (pending & ~clr_v) | set_v | rearm_v;
            // One counter serves both the request timeout and the post-request holdoff.
            if (state_next != state)                  cnt <= '0;
            else if (state == S_REQ || state == S_GAP) cnt <= cnt + 1'b1;
            if (take) begin
                cur_vec  <= sel_vec;
                rr_ptr   <= vec_inc(sel_vec);
                msi_addr <= cfg_msi_addr;
                msi_data <= msi_data_f(cfg_msi_data, cfg_mme, sel_vec);
            end
            if (req_ack)   issue_count <= issue_count + 16'd1;
            if (req_abort) err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_msi_irq_dispatch.sv
// Bench for msi_irq_dispatch: directed scenarios plus randomized bursts, with a
// responding write-master model and a round-robin reference model.
module tb_msi_irq_dispatch;
    localparam int N       = 8;
    localparam int HOLDOFF = 4;
    localparam int TIMEOUT = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_in;
    logic         msi_enable;
    logic [N-1:0] vec_mask;
    logic [31:0]  cfg_msi_addr;
    logic [15:0]  cfg_msi_data;
    logic [2:0]   cfg_mme;
    logic [7:0]   mst_state;
    logic         msi_start;
    logic [31:0]  msi_addr;
    logic [15:0]  msi_data;
    logic [N-1:0] pending;
    logic         busy;
    logic [15:0]  issue_count;
    logic         err_timeout;

    msi_irq_dispatch #(.NUM_VEC(N), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .msi_enable(msi_enable), .vec_mask(vec_mask),
        .cfg_msi_addr(cfg_msi_addr), .cfg_msi_data(cfg_msi_data), .cfg_mme(cfg_mme),
        .mst_state(mst_state), .msi_start(msi_start), .msi_addr(msi_addr), .msi_data(msi_data),
        .pending(pending), .busy(busy), .issue_count(issue_count), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_err = 0;
    int          n_checks = 0;
    logic [31:0] q_addr[$];
    logic [15:0] q_data[$];
    logic [31:0] e_addr[$];
    logic [15:0] e_data[$];
    int          rr_m = 0;
    int          exp_issue = 0;
    bit          mst_auto = 1'b1;
    int          m_delay = 1;
    int          m_len = 2;
    int          last_drop = 0;
    bit          have_drop = 1'b0;
    logic        prev_start = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_data(input int vec, input int base, input int mme);
        int a;
        a = 1 << mme;
        return 16'((base / a) * a + (vec % a));
    endfunction

    // Reference: every raised vector is issued once, scanning upward from the rr pointer.
    task automatic expect_burst(input logic [N-1:0] pat);
        int last;
        int v;
        last = -1;
        for (int k = 0; k < N; k++) begin
            v = (rr_m + k) % N;
            if (pat[v]) begin
                e_addr.push_back(cfg_msi_addr);
                e_data.push_back(exp_data(v, int'(cfg_msi_data), int'(cfg_mme)));
                exp_issue++;
                last = v;
            end
        end
        if (last >= 0) rr_m = (last + 1) % N;
    endtask

    task automatic compare_starts(input string tag);
        chk({tag, "_count"}, 64'(q_data.size()), 64'(e_data.size()));
        while (q_data.size() > 0 && e_data.size() > 0) begin
            chk({tag, "_addr"}, 64'(q_addr.pop_front()), 64'(e_addr.pop_front()));
            chk({tag, "_data"}, 64'(q_data.pop_front()), 64'(e_data.pop_front()));
        end
        q_addr.delete(); q_data.delete(); e_addr.delete(); e_data.delete();
    endtask

    task automatic pulse(input logic [N-1:0] p);
        @(negedge clk); irq_in = p;
        @(negedge clk); irq_in = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((busy || (msi_enable && (pending & ~vec_mask) != '0)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_reached"}, 64'(n < 2000), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        q_addr.delete(); q_data.delete(); e_addr.delete(); e_data.delete();
        rr_m = 0;
        exp_issue = 0;
    endtask

    // Write-master model: answers a start after m_delay cycles, stays busy m_len cycles.
    initial begin
        mst_state = 8'd0;
        forever begin
            @(negedge clk);
            if (mst_auto && msi_start === 1'b1 && mst_state == 8'd0) begin
                repeat (m_delay) @(negedge clk);
                mst_state = 8'h11;
                repeat (m_len) @(negedge clk);
                mst_state = 8'd0;
                last_drop = cyc + 1;
                have_drop = 1'b1;
            end
        end
    end

    // Start monitor: logs each handoff and checks holdoff after the master went idle.
    initial begin
        forever begin
            @(negedge clk);
            if (msi_start === 1'b1 && prev_start !== 1'b1) begin
                q_addr.push_back(msi_addr);
                q_data.push_back(msi_data);
                if (have_drop) chk("start_spacing", 64'((cyc - last_drop) >= HOLDOFF + 1), 64'd1);
            end
            prev_start = msi_start;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        logic [15:0] ic0;
        logic [N-1:0] pat;

        rst = 1'b1; irq_in = '0; msi_enable = 1'b1; vec_mask = '0;
        cfg_msi_addr = 32'hFEE0_0000; cfg_msi_data = 16'h4020; cfg_mme = 3'd3;
        repeat (3) @(negedge clk);
        chk("rst_start", 64'(msi_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_issue", 64'(issue_count), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_addr", 64'(msi_addr), 64'd0);
        chk("rst_data", 64'(msi_data), 64'd0);
        rst = 1'b0;

        // Single vector 3 with mme=3.
        pulse(8'h08);
        expect_burst(8'h08);
        wait_idle("t1");
        chk("t1_data_lit", 64'(msi_data), 64'h4023);
        compare_starts("t1");
        chk("t1_issue", 64'(issue_count), 64'd1);
        chk("t1_pending", 64'(pending), 64'd0);

        // All eight vectors together from a fresh rr pointer.
        do_reset();
        m_delay = 0; m_len = 1;
        pulse(8'hFF);
        expect_burst(8'hFF);
        wait_idle("t2");
        compare_starts("t2");
        chk("t2_issue", 64'(issue_count), 64'(exp_issue));

        // Aliasing with two allocated vectors.
        cfg_mme = 3'd1; m_delay = 2; m_len = 3;
        pulse(8'h40);
        expect_burst(8'h40);
        wait_idle("t3a");
        chk("t3a_data_lit", 64'(msi_data), 64'h4020);
        pulse(8'h20);
        expect_burst(8'h20);
        wait_idle("t3b");
        chk("t3b_data_lit", 64'(msi_data), 64'h4021);
        compare_starts("t3");

        // Masked vector stays pending until unmasked.
        vec_mask = 8'h04;
        pulse(8'h04);
        repeat (12) @(negedge clk);
        chk("t4_pending", 64'(pending), 64'h04);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_nostart", 64'(q_data.size()), 64'd0);
        vec_mask = '0;
        expect_burst(8'h04);
        wait_idle("t4");
        compare_starts("t4");
        chk("t4_pending_clr", 64'(pending), 64'd0);

        // Randomized bursts with random config and master timing.
        for (int it = 0; it < 6; it++) begin
            pat = N'($urandom_range(1, 255));
            cfg_mme = 3'($urandom_range(0, 5));
            cfg_msi_data = 16'($urandom);
            cfg_msi_addr = $urandom;
            m_delay = $urandom_range(0, 3);
            m_len = $urandom_range(1, 4);
            pulse(pat);
            expect_burst(pat);
            wait_idle("rnd");
            compare_starts("rnd");
            chk("rnd_issue", 64'(issue_count), 64'(exp_issue));
        end

        // Timeout: master never responds.
        mst_auto = 1'b0;
        cfg_mme = 3'd3; cfg_msi_data = 16'h4020; cfg_msi_addr = 32'hFEE0_0000;
        ic0 = issue_count;
        pulse(8'h02);
        n = 0;
        while (msi_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("t5_start_seen", 64'(n < 50), 64'd1);
        hi = 0;
        while (msi_start === 1'b1 && hi < TIMEOUT + 20) begin hi++; @(negedge clk); end
        msi_enable = 1'b0;
        chk("t5_high_cycles", 64'(hi), 64'(TIMEOUT));
        chk("t5_err", 64'(err_timeout), 64'd1);
        chk("t5_rearmed", 64'(pending), 64'h02);
        expect_burst(8'h02);
        exp_issue--;
        repeat (10) @(negedge clk);
        chk("t5_hold_busy", 64'(busy), 64'd0);
        chk("t5_hold_pending", 64'(pending), 64'h02);
        chk("t5_issue_same", 64'(issue_count), 64'(ic0));
        mst_auto = 1'b1; msi_enable = 1'b1;
        expect_burst(8'h02);
        wait_idle("t5");
        compare_starts("t5");
        chk("t5_issue", 64'(issue_count), 64'(exp_issue));
        chk("t5_err_sticky", 64'(err_timeout), 64'd1);

        // Re-raise vector 1 while its MSI is in flight.
        m_delay = 0; m_len = 6;
        ic0 = issue_count;
        pulse(8'h02);
        n = 0;
        while (issue_count == ic0 && n < 50) begin @(negedge clk); n++; end
        chk("t6_acked", 64'(n < 50), 64'd1);
        irq_in = 8'h02;
        @(negedge clk); irq_in = '0;
        chk("t6_repend", 64'(pending[1]), 64'd1);
        chk("t6_busy", 64'(busy), 64'd1);
        expect_burst(8'h02);
        expect_burst(8'h02);
        wait_idle("t6");
        compare_starts("t6");
        chk("t6_issue", 64'(issue_count), 64'(exp_issue));

        // Reset while a request is waiting on the master.
        mst_auto = 1'b0;
        pulse(8'h03);
        n = 0;
        while (msi_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("t7_start_seen", 64'(n < 50), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_start", 64'(msi_start), 64'd0);
        chk("t7_pending", 64'(pending), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_issue", 64'(issue_count), 64'd0);
        chk("t7_err", 64'(err_timeout), 64'd0);
        rst = 1'b0;
        q_addr.delete(); q_data.delete();
        repeat (20) @(negedge clk);
        chk("t7_quiet", 64'(q_data.size()), 64'd0);
        chk("t7_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
